// File: rtl/poly_add_seq_pkg.sv
// Shared types and constants for the sequential polynomial adder.
// Default DEG/N, FSM state encodings, op encodings and a clog2 helper.
package poly_add_seq_pkg;

  localparam int DEG_DEF = 4;
  localparam int N_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width needed to index v items; never below 1 so a counter always exists.
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/poly_add_seq_coeff_addsub.sv
// Combinational N-bit coefficient adder; subtract path (POLY_SUB_EN) inverts b with carry-in 1.
// wrap is the carry-out for add and the borrow for subtract.
module coeff_addsub #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef POLY_SUB_EN
  input  logic         sub,
`endif
  output logic [N-1:0] y,
  output logic         wrap
);

  logic [N:0] full;

`ifdef POLY_SUB_EN
  // Borrow is the inverted carry-out of a + ~b + 1.
  assign full = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};
  assign wrap = full[N] ^ sub;
`else
  assign full = {1'b0, a} + {1'b0, b};
  assign wrap = full[N];
`endif

  assign y = full[N-1:0];

endmodule

// File: rtl/poly_add_seq.sv
// Time-shared polynomial adder: one coefficient per cycle over a valid/ready job handshake.
// Define POLY_SUB_EN to add the op port and per-job subtract support.
module poly_add_seq
  import poly_add_seq_pkg::*;
#(
  parameter int DEG = DEG_DEF,
  parameter int N   = N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEG*N-1:0] a,
  input  logic [DEG*N-1:0] b,
`ifdef POLY_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEG*N-1:0] s,
  output logic [DEG-1:0]   ovf,
  output logic             busy
);

  localparam int IW = clog2(DEG);
  localparam logic [IW-1:0] LAST = IW'(DEG - 1);

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [N-1:0]    a_reg [DEG];
  logic [N-1:0]    b_reg [DEG];
  logic [N-1:0]    s_reg [DEG];
  logic [N-1:0]    a_coef [DEG];
  logic [N-1:0]    b_coef [DEG];
  logic [DEG-1:0]  ovf_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;
  logic [N-1:0]    sum_next;
  logic            wrap_next;
`ifdef POLY_SUB_EN
  logic            op_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEG; gi++) begin : g_coef
      assign a_coef[gi]       = a[gi*N +: N];
      assign b_coef[gi]       = b[gi*N +: N];
      assign s[gi*N +: N]     = s_reg[gi];
    end
  endgenerate

  coeff_addsub #(.N(N)) u_addsub (
    .a    (a_reg[idx_reg]),
    .b    (b_reg[idx_reg]),
`ifdef POLY_SUB_EN
    .sub  (op_reg),
`endif
    .y    (sum_next),
    .wrap (wrap_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      ovf_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef POLY_SUB_EN
      op_reg        <= OP_ADD;
`endif
      for (int i = 0; i < DEG; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
        s_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            for (int i = 0; i < DEG; i++) begin
              a_reg[i] <= a_coef[i];
              b_reg[i] <= b_coef[i];
              s_reg[i] <= '0;
            end
`ifdef POLY_SUB_EN
            op_reg       <= op;
`endif
            idx_reg      <= '0;
            ovf_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          s_reg[idx_reg]   <= sum_next;
          ovf_reg[idx_reg] <= wrap_next;
          // idx parks on the last coefficient rather than wrapping.
          if (idx_reg == LAST) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign ovf       = ovf_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_poly_add_seq.sv
// Directed self-checking bench for poly_add_seq (DEG=4, N=4).
// Define POLY_SUB_EN to also exercise the subtract path.
module tb_poly_add_seq;

  localparam int DEG = 4;
  localparam int N   = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DEG*N-1:0] a;
  logic [DEG*N-1:0] b;
`ifdef POLY_SUB_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [DEG*N-1:0] s;
  logic [DEG-1:0]   ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_accept = 0;

  poly_add_seq #(.DEG(DEG), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef POLY_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one job, follow it to out_valid, then hold out_ready low for hold cycles.
  task automatic run_job(input logic [15:0] av, input logic [15:0] bv, input logic opv,
                         input logic [15:0] s_exp, input logic [3:0] ovf_exp, input int hold);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
`ifdef POLY_SUB_EN
    op = opv;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    last_accept = cyc;
    in_valid = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    for (int k = 1; k <= DEG; k++) begin
      @(posedge clk); #1;
      check("in_ready_low", {31'd0, in_ready}, 32'd0);
      if (k < DEG) check("out_valid_early", {31'd0, out_valid}, 32'd0);
    end
    check("out_valid_lat", {31'd0, out_valid}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd1);
    check("s", {16'd0, s}, {16'd0, s_exp});
    check("ovf", {28'd0, ovf}, {28'd0, ovf_exp});
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      a = 16'h0000;
      b = 16'h0000;
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_s", {16'd0, s}, {16'd0, s_exp});
      check("bp_ovf", {28'd0, ovf}, {28'd0, ovf_exp});
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
    check("release_busy", {31'd0, busy}, 32'd0);
    $display("txn a=%h b=%h op=%0d s=%h ovf=%b accept_cyc=%0d", av, bv, opv, s, ovf, last_accept);
  endtask

  initial begin
    int prev_accept;
    logic seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef POLY_SUB_EN
    op        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_ovf", {28'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    run_job(16'hAA5F, 16'hAA5F, 1'b0, 16'h44AE, 4'b1101, 0);
    prev_accept = last_accept;
    run_job(16'h1234, 16'h4321, 1'b0, 16'h5555, 4'b0000, 10);
    // Job A was released immediately, so job B should start at the minimum interval.
    check("interval_add", last_accept - prev_accept, 32'd6);

    // Abandon a job two cycles in.
    a = 16'hFFFF;
    b = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_busy", {31'd0, busy}, 32'd0);
    check("midrun_s", {16'd0, s}, 32'd0);
    check("midrun_ovf", {28'd0, ovf}, 32'd0);
    check("midrun_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | out_valid;
    end
    check("midrun_no_result", {31'd0, seen_valid}, 32'd0);
    run_job(16'h0001, 16'h000F, 1'b0, 16'h0000, 4'b0001, 0);

`ifdef POLY_SUB_EN
    run_job(16'h1234, 16'h2111, 1'b1, 16'hF123, 4'b1000, 0);
    prev_accept = last_accept;
    run_job(16'h1234, 16'h2111, 1'b1, 16'hF123, 4'b1000, 0);
    check("interval_sub", last_accept - prev_accept, 32'd6);
    run_job(16'h0F0F, 16'h0F0F, 1'b1, 16'h0000, 4'b0000, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
